// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone classic arbiter sharing one slave port among NM masters.
// Optional slave-ack watchdog (abort with m_err_o) is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rstn_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM-1:0]        m_cyc_i,
    output logic [DW-1:0]        m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic                 s_we_o,
    output logic                 s_stb_o,
    output logic                 s_cyc_o,
    input  logic [DW-1:0]        s_dat_i,
    input  logic                 s_ack_i,
    output logic [NM-1:0]        gnt_o
);

    localparam int IW = $clog2(NM);
    localparam int SW = DW / 8;

    if (NM < 2 || NM > 8 || TIMEOUT < 1) begin : g_param_check
        $error("wb_rr_arbiter: NM must be 2..8 and TIMEOUT must be >= 1");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt, cnt_nxt;
`else
    typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

    state_t        state, state_nxt;
    logic [NM-1:0] gnt_nxt;
    logic [IW-1:0] gidx, gidx_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [IW-1:0] ptr_after;
    logic [IW-1:0] pick;
    logic          found;

    assign m_dat_o   = s_dat_i;
    assign ptr_after = (gidx == IW'(NM - 1)) ? '0 : gidx + IW'(1);

    // First requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NM; i++) begin
            if (!found && m_cyc_i[(int'(ptr) + i) % NM]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr) + i) % NM);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_o;
        gidx_nxt  = gidx;
        ptr_nxt   = ptr;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_stb_o   = 1'b0;
        s_cyc_o   = 1'b0;
        m_ack_o   = '0;
        m_err_o   = '0;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_nxt   = '0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    gnt_nxt   = NM'(1) << pick;
                    gidx_nxt  = pick;
                end
            end
            BUSY: begin
                s_adr_o         = m_adr_i[gidx*AW +: AW];
                s_dat_o         = m_dat_i[gidx*DW +: DW];
                s_sel_o         = m_sel_i[gidx*SW +: SW];
                s_we_o          = m_we_i[gidx];
                s_stb_o         = m_stb_i[gidx] & m_cyc_i[gidx];
                s_cyc_o         = m_cyc_i[gidx];
                m_ack_o[gidx]   = s_ack_i & m_cyc_i[gidx];
                if (!m_cyc_i[gidx]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = ptr_after;
                end
`ifdef WB_ARB_TIMEOUT_EN
                // Error fires on the TIMEOUT-th consecutive unacknowledged strobe cycle.
                else begin
                    cnt_nxt = cnt;
                    if (s_ack_i) begin
                        cnt_nxt = '0;
                    end else if (s_stb_o) begin
                        if (cnt == CW'(TIMEOUT - 1)) begin
                            m_err_o[gidx] = 1'b1;
                            state_nxt     = ABORT;
                            cnt_nxt       = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                if (!m_cyc_i[gidx]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = ptr_after;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state <= IDLE;
            gnt_o <= '0;
            gidx  <= '0;
            ptr   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_nxt;
            gnt_o <= gnt_nxt;
            gidx  <= gidx_nxt;
            ptr   <= ptr_nxt;
`ifdef WB_ARB_TIMEOUT_EN
            cnt   <= cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus randomized traffic
// compared against an owner/pointer reference model.
module tb_wb_rr_arbiter;

    localparam int NM         = 2;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int SW         = DW / 8;
    localparam int TB_TIMEOUT = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                 wb_clk_i;
    logic                 wb_rstn_i;
    logic [NM*AW-1:0]     m_adr_i;
    logic [NM*DW-1:0]     m_dat_i;
    logic [NM*SW-1:0]     m_sel_i;
    logic [NM-1:0]        m_we_i;
    logic [NM-1:0]        m_stb_i;
    logic [NM-1:0]        m_cyc_i;
    logic [DW-1:0]        m_dat_o;
    logic [NM-1:0]        m_ack_o;
    logic [NM-1:0]        m_err_o;
    logic [AW-1:0]        s_adr_o;
    logic [DW-1:0]        s_dat_o;
    logic [SW-1:0]        s_sel_o;
    logic                 s_we_o;
    logic                 s_stb_o;
    logic                 s_cyc_o;
    logic [DW-1:0]        s_dat_i;
    logic                 s_ack_i;
    logic [NM-1:0]        gnt_o;

    wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TB_TIMEOUT)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rstn_i(wb_rstn_i),
        .m_adr_i  (m_adr_i),
        .m_dat_i  (m_dat_i),
        .m_sel_i  (m_sel_i),
        .m_we_i   (m_we_i),
        .m_stb_i  (m_stb_i),
        .m_cyc_i  (m_cyc_i),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_stb_o  (s_stb_o),
        .s_cyc_o  (s_cyc_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .gnt_o    (gnt_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model: who owns the slave (-1 = nobody), where the next search starts,
    // and the watchdog's view of consecutive unacknowledged strobes.
    int owner    = -1;
    int rr_next  = 0;
    bit aborted  = 1'b0;
    int wait_cnt = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    endtask

    task automatic resetModel();
        owner    = -1;
        rr_next  = 0;
        aborted  = 1'b0;
        wait_cnt = 0;
    endtask

    // Directed stimulus: master k uses address 0x100 + k*0x1000 so the mux choice is visible.
    task automatic applyStimulus(input logic [NM-1:0] cyc, input logic [NM-1:0] stb,
                                 input logic [NM-1:0] we, input logic ack, input logic [DW-1:0] sdat);
        m_cyc_i = cyc;
        m_stb_i = stb;
        m_we_i  = we;
        s_ack_i = ack;
        s_dat_i = sdat;
        for (int k = 0; k < NM; k++) begin
            m_adr_i[k*AW +: AW] = AW'(32'h100 + k * 32'h1000);
            m_dat_i[k*DW +: DW] = DW'($urandom);
            m_sel_i[k*SW +: SW] = SW'($urandom);
        end
    endtask

    // Compare every output against what the model says for the current inputs.
    task automatic checkModel();
        logic [NM-1:0] e_gnt, e_ack, e_err;
        logic          e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        #1;
        e_gnt = '0; e_ack = '0; e_err = '0;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_adr = '0; e_dat = '0; e_sel = '0;
        if (owner >= 0) begin
            e_gnt[owner] = 1'b1;
            if (!aborted) begin
                e_cyc = m_cyc_i[owner];
                e_stb = m_stb_i[owner] & m_cyc_i[owner];
                e_we  = m_we_i[owner];
                e_adr = m_adr_i[owner*AW +: AW];
                e_dat = m_dat_i[owner*DW +: DW];
                e_sel = m_sel_i[owner*SW +: SW];
                e_ack[owner] = s_ack_i & m_cyc_i[owner];
                if (TO_EN && e_stb && !s_ack_i && wait_cnt == TB_TIMEOUT - 1) e_err[owner] = 1'b1;
            end
        end
        checkOutput("gnt_o", 64'(gnt_o), 64'(e_gnt));
        checkOutput("s_cyc_o", 64'(s_cyc_o), 64'(e_cyc));
        checkOutput("s_stb_o", 64'(s_stb_o), 64'(e_stb));
        checkOutput("s_we_o", 64'(s_we_o), 64'(e_we));
        checkOutput("s_adr_o", 64'(s_adr_o), 64'(e_adr));
        checkOutput("s_dat_o", 64'(s_dat_o), 64'(e_dat));
        checkOutput("s_sel_o", 64'(s_sel_o), 64'(e_sel));
        checkOutput("m_ack_o", 64'(m_ack_o), 64'(e_ack));
        checkOutput("m_err_o", 64'(m_err_o), 64'(e_err));
        checkOutput("m_dat_o", 64'(m_dat_o), 64'(s_dat_i));
    endtask

    // Advance the model across the clock edge using the inputs held during the cycle.
    task automatic finishCycle();
        bit got;
        @(posedge wb_clk_i);
        if (!wb_rstn_i) begin
            resetModel();
        end else if (owner < 0) begin
            got = 1'b0;
            for (int i = 0; i < NM; i++) begin
                if (!got && m_cyc_i[(rr_next + i) % NM]) begin
                    got      = 1'b1;
                    owner    = (rr_next + i) % NM;
                    aborted  = 1'b0;
                    wait_cnt = 0;
                end
            end
        end else if (!m_cyc_i[owner]) begin
            rr_next  = (owner + 1) % NM;
            owner    = -1;
            wait_cnt = 0;
        end else if (TO_EN && !aborted) begin
            if (s_ack_i) wait_cnt = 0;
            else if (m_stb_i[owner]) begin
                if (wait_cnt == TB_TIMEOUT - 1) begin
                    aborted  = 1'b1;
                    wait_cnt = 0;
                end else wait_cnt++;
            end
        end
        @(negedge wb_clk_i);
    endtask

    // Asynchronous reset between edges: outputs must clear without any clock.
    task automatic pulseReset();
        #2 wb_rstn_i = 1'b0;
        #1;
        checkOutput("rst_s_cyc_o", 64'(s_cyc_o), 64'd0);
        checkOutput("rst_s_stb_o", 64'(s_stb_o), 64'd0);
        checkOutput("rst_gnt_o", 64'(gnt_o), 64'd0);
        checkOutput("rst_m_ack_o", 64'(m_ack_o), 64'd0);
        checkOutput("rst_m_err_o", 64'(m_err_o), 64'd0);
        resetModel();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rstn_i = 1'b1;
    endtask

    initial begin
        logic [NM-1:0] req;
        int            ack_pct;
        int            ack0_count;
        int            ack1_count;

        wb_rstn_i = 1'b0;
        applyStimulus('0, '0, '0, 1'b0, '0);
        @(negedge wb_clk_i);
        checkOutput("init_gnt_o", 64'(gnt_o), 64'd0);
        checkOutput("init_s_cyc_o", 64'(s_cyc_o), 64'd0);
        @(negedge wb_clk_i);
        wb_rstn_i = 1'b1;

        $display("[TB] single master read");
        applyStimulus(2'b01, 2'b01, 2'b00, 1'b0, '0);
        checkModel();
        checkOutput("t2_gnt_before", 64'(gnt_o), 64'd0);
        finishCycle();
        applyStimulus(2'b01, 2'b01, 2'b00, 1'b0, '0);
        checkModel();
        checkOutput("t2_gnt", 64'(gnt_o), 64'b01);
        checkOutput("t2_s_adr_o", 64'(s_adr_o), 64'h100);
        checkOutput("t2_s_cyc_o", 64'(s_cyc_o), 64'd1);
        finishCycle();
        applyStimulus(2'b01, 2'b01, 2'b00, 1'b1, 32'hDEADBEEF);
        checkModel();
        checkOutput("t2_m_ack_o", 64'(m_ack_o), 64'b01);
        checkOutput("t2_m_dat_o", 64'(m_dat_o), 64'hDEADBEEF);
        finishCycle();
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, '0);
        checkModel();
        finishCycle();
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, '0);
        checkModel();
        checkOutput("t2_gnt_after", 64'(gnt_o), 64'd0);
        finishCycle();

        $display("[TB] contention and fair alternation");
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, '0);
        checkModel();
        pulseReset();
        applyStimulus(2'b11, 2'b11, 2'b00, 1'b0, '0);
        checkModel();
        finishCycle();
        applyStimulus(2'b11, 2'b11, 2'b00, 1'b0, '0);
        checkModel();
        checkOutput("t3_first_gnt", 64'(gnt_o), 64'b01);
        finishCycle();
        applyStimulus(2'b10, 2'b10, 2'b00, 1'b0, '0);
        checkModel();
        finishCycle();
        applyStimulus(2'b10, 2'b10, 2'b00, 1'b0, '0);
        checkModel();
        checkOutput("t3_bubble_gnt", 64'(gnt_o), 64'd0);
        finishCycle();
        applyStimulus(2'b10, 2'b10, 2'b00, 1'b0, '0);
        checkModel();
        checkOutput("t3_second_gnt", 64'(gnt_o), 64'b10);
        finishCycle();
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, '0);
        checkModel();
        finishCycle();
        applyStimulus(2'b11, 2'b11, 2'b00, 1'b0, '0);
        checkModel();
        finishCycle();
        applyStimulus(2'b11, 2'b11, 2'b00, 1'b0, '0);
        checkModel();
        checkOutput("t3_third_gnt", 64'(gnt_o), 64'b01);
        finishCycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, '0);
            checkModel();
            finishCycle();
        end

        $display("[TB] no preemption during burst");
        ack0_count = 0;
        ack1_count = 0;
        applyStimulus(2'b01, 2'b01, 2'b00, 1'b0, '0);
        checkModel();
        finishCycle();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) applyStimulus(2'b11, 2'b11, 2'b00, 1'b1, DW'($urandom));
            else       applyStimulus(2'b10, 2'b10, 2'b00, 1'b0, '0);
            checkModel();
            ack0_count += int'(m_ack_o[0]);
            ack1_count += int'(m_ack_o[1]);
            finishCycle();
        end
        checkOutput("t4_m0_acks", 64'(ack0_count), 64'd4);
        checkOutput("t4_m1_acks", 64'(ack1_count), 64'd0);
        applyStimulus(2'b10, 2'b10, 2'b00, 1'b0, '0);
        checkModel();
        checkOutput("t4_m1_gnt", 64'(gnt_o), 64'b10);
        finishCycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, '0);
            checkModel();
            finishCycle();
        end

        $display("[TB] stray ack in idle");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'b00, 2'b01, 2'b00, 1'b1, DW'($urandom));
            checkModel();
            checkOutput("t5_m_ack_o", 64'(m_ack_o), 64'd0);
            finishCycle();
        end
        applyStimulus(2'b01, 2'b01, 2'b00, 1'b0, '0);
        checkModel();
        checkOutput("t5_idle_gnt", 64'(gnt_o), 64'd0);
        finishCycle();

        $display("[TB] async reset mid-cycle");
        applyStimulus(2'b01, 2'b01, 2'b00, 1'b1, 32'h12345678);
        checkModel();
        checkOutput("t1_busy_ack", 64'(m_ack_o), 64'b01);
        checkOutput("t1_busy_cyc", 64'(s_cyc_o), 64'd1);
        pulseReset();
        applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, '0);
        checkModel();
        finishCycle();

        if (TO_EN) begin
            $display("[TB] watchdog timeout");
            applyStimulus(2'b10, 2'b10, 2'b10, 1'b0, '0);
            checkModel();
            finishCycle();
            for (int w = 1; w <= 9; w++) begin
                applyStimulus(2'b10, 2'b10, 2'b10, 1'b0, '0);
                checkModel();
                checkOutput("t6_m_err_o", 64'(m_err_o), (w == 8) ? 64'b10 : 64'd0);
                if (w == 9) begin
                    checkOutput("t6_abort_cyc", 64'(s_cyc_o), 64'd0);
                    checkOutput("t6_abort_gnt", 64'(gnt_o), 64'b10);
                end
                finishCycle();
            end
            applyStimulus(2'b00, 2'b00, 2'b00, 1'b1, '0);
            checkModel();
            checkOutput("t6_abort_ack", 64'(m_ack_o), 64'd0);
            finishCycle();
            applyStimulus(2'b00, 2'b00, 2'b00, 1'b0, '0);
            checkModel();
            checkOutput("t6_idle_gnt", 64'(gnt_o), 64'd0);
            finishCycle();
        end

        $display("[TB] randomized traffic");
        req     = '0;
        ack_pct = 50;
        for (int c = 0; c < 1500; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(0, 3))
                    0:       ack_pct = 0;
                    1:       ack_pct = 30;
                    default: ack_pct = 70;
                endcase
            end
            for (int k = 0; k < NM; k++) begin
                if (req[k]) req[k] = ($urandom_range(0, 5) != 0);
                else        req[k] = ($urandom_range(0, 2) == 0);
                m_adr_i[k*AW +: AW] = AW'($urandom);
                m_dat_i[k*DW +: DW] = DW'($urandom);
                m_sel_i[k*SW +: SW] = SW'($urandom);
            end
            m_cyc_i = req;
            m_stb_i = NM'($urandom);
            m_we_i  = NM'($urandom);
            s_ack_i = ($urandom_range(0, 99) < ack_pct);
            s_dat_i = DW'($urandom);
            checkModel();
            if (c == 750) pulseReset();
            else          finishCycle();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
